// File: rtl/audio_pkg.sv
// Shared definitions for the 10 kHz audio sample path.
// Holds the sample width, sequencer state encoding and default stall limit.
package audio_pkg;
  localparam int DW                  = 10;
  localparam int SEQ_TIMEOUT_DEFAULT = 1023;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ADC_WAIT  = 2'd1,
    PROC_WAIT = 2'd2
  } seq_state_t;
endpackage

// File: rtl/wait_timer.sv
// Loadable up-counter with synchronous clear and a terminal-count flag.
// o_tc flags the last permitted counting cycle (count == TERMINAL-1).
module wait_timer #(
  parameter int TERMINAL = 1023,
  parameter int CW       = $clog2(TERMINAL + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  output logic          o_tc
);
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = i_en && (r_cnt == CW'(TERMINAL - 1));
endmodule

// File: rtl/sample_sequencer.sv
// One-sample-in-flight scheduler: tick -> ADC -> processor -> DAC load,
// with dropped-tick (overrun) accounting and per-stage stall abort.
module sample_sequencer
  import audio_pkg::*;
#(
  parameter int DW      = audio_pkg::DW,
  parameter int TIMEOUT = SEQ_TIMEOUT_DEFAULT
) (
  input  logic          sysclk,
  input  logic          reset,
  input  logic          tick,
  input  logic          bypass,
  input  logic          clr_err,
  output logic          adc_start,
  input  logic          adc_valid,
  input  logic [DW-1:0] adc_data,
  output logic          proc_start,
  output logic [DW-1:0] proc_din,
  input  logic          proc_done,
  input  logic [DW-1:0] proc_dout,
  output logic          dac_load,
  output logic [DW-1:0] dac_data,
  output logic          busy,
  output logic          overrun,
  output logic [7:0]    overrun_cnt,
  output logic          timeout_err,
  output logic [15:0]   sample_cnt
);
  seq_state_t    r_state, w_state_next;
  logic          r_adc_valid_d;
  logic          r_adc_start, r_proc_start, r_dac_load, r_busy, r_overrun, r_timeout_err;
  logic [DW-1:0] r_proc_din, r_dac_data;
  logic [7:0]    r_overrun_cnt;
  logic [15:0]   r_sample_cnt;
  logic          w_adc_rise, w_tc, w_drop;
  logic          w_adc_go, w_capture, w_proc_go, w_load, w_abort;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  assign w_adc_rise = adc_valid && !r_adc_valid_d;
  assign w_drop     = tick && (r_state != IDLE);

  // Counter restarts on every state change and idles at zero outside the wait states
  wait_timer #(.TERMINAL(TIMEOUT)) u_wait_timer (
    .i_clk      (sysclk),
    .i_rst      (reset),
    .i_clr      ((w_state_next != r_state) || (r_state == IDLE)),
    .i_en       (r_state != IDLE),
    .i_load     (1'b0),
    .i_load_val ('0),
    .o_tc       (w_tc)
  );

  always_comb begin
    w_state_next = r_state;
    w_adc_go     = 1'b0;
    w_capture    = 1'b0;
    w_proc_go    = 1'b0;
    w_load       = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      IDLE: begin
        if (tick) begin
          w_state_next = ADC_WAIT;
          w_adc_go     = 1'b1;
        end
      end
      ADC_WAIT: begin
        if (w_adc_rise) begin
          w_capture = 1'b1;
          if (bypass) begin
            w_load       = 1'b1;
            w_state_next = IDLE;
          end else begin
            w_proc_go    = 1'b1;
            w_state_next = PROC_WAIT;
          end
        end else if (w_tc) begin
          w_abort      = 1'b1;
          w_state_next = IDLE;
        end
      end
      PROC_WAIT: begin
        if (proc_done) begin
          w_load       = 1'b1;
          w_state_next = IDLE;
        end else if (w_tc) begin
          w_abort      = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_adc_valid_d <= 1'b0;
      r_adc_start   <= 1'b0;
      r_proc_start  <= 1'b0;
      r_dac_load    <= 1'b0;
      r_busy        <= 1'b0;
      r_overrun     <= 1'b0;
      r_timeout_err <= 1'b0;
      r_proc_din    <= '0;
      r_dac_data    <= '0;
      r_overrun_cnt <= '0;
      r_sample_cnt  <= '0;
    end else begin
      r_state       <= w_state_next;
      r_adc_valid_d <= adc_valid;
      r_adc_start   <= w_adc_go;
      r_proc_start  <= w_proc_go;
      r_dac_load    <= w_load;
      r_busy        <= (w_state_next != IDLE);
      r_overrun     <= w_drop;
      if (w_capture) r_proc_din <= adc_data;
      if (w_load) begin
        r_dac_data   <= (r_state == ADC_WAIT) ? adc_data : proc_dout;
        r_sample_cnt <= r_sample_cnt + 16'd1;
      end
      // A same-cycle drop outranks clr_err: the count restarts at one
      if (w_drop)       r_overrun_cnt <= clr_err ? 8'd1 : sat_inc8(r_overrun_cnt);
      else if (clr_err) r_overrun_cnt <= '0;
      if (w_abort)      r_timeout_err <= 1'b1;
      else if (clr_err) r_timeout_err <= 1'b0;
    end
  end

  assign adc_start   = r_adc_start;
  assign proc_start  = r_proc_start;
  assign proc_din    = r_proc_din;
  assign dac_load    = r_dac_load;
  assign dac_data    = r_dac_data;
  assign busy        = r_busy;
  assign overrun     = r_overrun;
  assign overrun_cnt = r_overrun_cnt;
  assign timeout_err = r_timeout_err;
  assign sample_cnt  = r_sample_cnt;
endmodule

// File: tb/tb_sample_sequencer.sv
// Scoreboard bench for sample_sequencer: a long-timeout instance for the main
// sequences and a TIMEOUT=15 instance, sharing stimulus, for the abort case.
module tb_sample_sequencer;
  localparam int DW = 10;

  logic          sysclk = 1'b0;
  logic          reset, tick, bypass, clr_err, adc_valid, proc_done;
  logic [DW-1:0] adc_data, proc_dout;

  logic          adc_start, proc_start, dac_load, busy, overrun, timeout_err;
  logic [DW-1:0] proc_din, dac_data;
  logic [7:0]    overrun_cnt;
  logic [15:0]   sample_cnt;

  logic          to_adc_start, to_proc_start, to_dac_load, to_busy, to_overrun, to_timeout_err;
  logic [DW-1:0] to_proc_din, to_dac_data;
  logic [7:0]    to_overrun_cnt;
  logic [15:0]   to_sample_cnt;

  always #5 sysclk = ~sysclk;

  sample_sequencer #(.DW(DW), .TIMEOUT(1023)) dut (
    .sysclk(sysclk), .reset(reset), .tick(tick), .bypass(bypass), .clr_err(clr_err),
    .adc_start(adc_start), .adc_valid(adc_valid), .adc_data(adc_data),
    .proc_start(proc_start), .proc_din(proc_din), .proc_done(proc_done), .proc_dout(proc_dout),
    .dac_load(dac_load), .dac_data(dac_data), .busy(busy), .overrun(overrun),
    .overrun_cnt(overrun_cnt), .timeout_err(timeout_err), .sample_cnt(sample_cnt)
  );

  sample_sequencer #(.DW(DW), .TIMEOUT(15)) dut_to (
    .sysclk(sysclk), .reset(reset), .tick(tick), .bypass(bypass), .clr_err(clr_err),
    .adc_start(to_adc_start), .adc_valid(adc_valid), .adc_data(adc_data),
    .proc_start(to_proc_start), .proc_din(to_proc_din), .proc_done(proc_done), .proc_dout(proc_dout),
    .dac_load(to_dac_load), .dac_data(to_dac_data), .busy(to_busy), .overrun(to_overrun),
    .overrun_cnt(to_overrun_cnt), .timeout_err(to_timeout_err), .sample_cnt(to_sample_cnt)
  );

  int n_pass = 0;
  int n_total = 0;
  int exp_proc[$];
  int exp_dac_data[$];
  int exp_dac_cnt[$];
  int n_adc_start = 0, n_proc_start = 0, n_dac_load = 0, n_overrun = 0, n_to_dac_load = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: pops the scoreboard whenever the main instance presents a handshake
  always @(negedge sysclk) begin
    if (adc_start)   n_adc_start++;
    if (overrun)     n_overrun++;
    if (to_dac_load) n_to_dac_load++;
    if (proc_start) begin
      n_proc_start++;
      if (exp_proc.size() == 0) check("unexpected proc_start (queue depth)", exp_proc.size(), 1);
      else check("proc_din at proc_start", int'(proc_din), exp_proc.pop_front());
    end
    if (dac_load) begin
      n_dac_load++;
      if (exp_dac_data.size() == 0) check("unexpected dac_load (queue depth)", exp_dac_data.size(), 1);
      else begin
        check("dac_data at dac_load", int'(dac_data), exp_dac_data.pop_front());
        check("sample_cnt at dac_load", int'(sample_cnt), exp_dac_cnt.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick = 1'b0; bypass = 1'b0; clr_err = 1'b0;
    adc_valid = 1'b0; proc_done = 1'b0; adc_data = '0; proc_dout = '0;
    cyc(2);
    reset = 1'b0;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
  endtask

  int a0, o0, p0, d0, t0;

  initial begin
    do_reset();
    check("reset busy", busy, 0);
    check("reset adc_start", adc_start, 0);
    check("reset dac_data", dac_data, 0);
    check("reset proc_din", proc_din, 0);
    check("reset sample_cnt", sample_cnt, 0);
    check("reset overrun_cnt", overrun_cnt, 0);
    check("reset timeout_err", timeout_err, 0);

    // Normal processed sample
    pulse_tick();
    check("adc_start after tick", adc_start, 1);
    check("busy after tick", busy, 1);
    cyc(1);
    check("adc_start single cycle", adc_start, 0);
    cyc(38);
    adc_data = 10'h2A5; adc_valid = 1'b1; exp_proc.push_back('h2A5);
    cyc(1);
    check("proc_start one cycle after edge", proc_start, 1);
    check("proc_din captured", proc_din, 'h2A5);
    cyc(2);
    proc_dout = 10'h15A; proc_done = 1'b1;
    exp_dac_data.push_back('h15A); exp_dac_cnt.push_back(1);
    cyc(1);
    proc_done = 1'b0; adc_valid = 1'b0;
    check("dac_load one cycle after done", dac_load, 1);
    check("dac_data processed", dac_data, 'h15A);
    check("sample_cnt after first", sample_cnt, 1);
    check("busy low after done", busy, 0);
    cyc(1);
    check("dac_load single cycle", dac_load, 0);

    // Bypass sample
    p0 = n_proc_start;
    bypass = 1'b1;
    pulse_tick();
    cyc(5);
    adc_data = 10'h3FF; adc_valid = 1'b1;
    exp_dac_data.push_back('h3FF); exp_dac_cnt.push_back(2);
    cyc(1);
    check("bypass dac_load one cycle after edge", dac_load, 1);
    check("bypass dac_data", dac_data, 'h3FF);
    check("bypass proc_din", proc_din, 'h3FF);
    check("bypass busy low", busy, 0);
    adc_valid = 1'b0; bypass = 1'b0;
    cyc(2);
    check("bypass no proc_start", n_proc_start, p0);

    // Overrun and saturation
    do_reset();
    a0 = n_adc_start; o0 = n_overrun;
    pulse_tick();
    cyc(9);
    pulse_tick();
    check("overrun pulse", overrun, 1);
    check("overrun_cnt one", overrun_cnt, 1);
    cyc(5);
    check("single adc_start", n_adc_start - a0, 1);
    check("single overrun pulse", n_overrun - o0, 1);
    tick = 1'b1;
    cyc(300);
    tick = 1'b0;
    cyc(2);
    check("overrun_cnt saturates", overrun_cnt, 255);
    check("overrun pulses counted", n_overrun - o0, 301);
    check("still one adc_start", n_adc_start - a0, 1);
    clr_err = 1'b1;
    cyc(1);
    clr_err = 1'b0;
    check("clr_err clears overrun_cnt", overrun_cnt, 0);
    tick = 1'b1; clr_err = 1'b1;
    cyc(1);
    tick = 1'b0; clr_err = 1'b0;
    check("overrun beats clr_err", overrun_cnt, 1);
    check("overrun pulse with clr_err", overrun, 1);

    // Timeout on the TIMEOUT=15 instance, after seeding its dac_data
    do_reset();
    bypass = 1'b1;
    pulse_tick();
    cyc(3);
    adc_data = 10'h123; adc_valid = 1'b1;
    exp_dac_data.push_back('h123); exp_dac_cnt.push_back(1);
    cyc(1);
    adc_valid = 1'b0; bypass = 1'b0;
    check("timeout seed dac_data", to_dac_data, 'h123);
    cyc(1);
    t0 = n_to_dac_load;
    pulse_tick();
    cyc(3);
    adc_data = 10'h0F0; adc_valid = 1'b1; exp_proc.push_back('h0F0);
    cyc(1);
    adc_valid = 1'b0;
    check("timeout proc_start", to_proc_start, 1);
    cyc(14);
    check("still busy 14 cycles after proc_start", to_busy, 1);
    check("no timeout_err yet", to_timeout_err, 0);
    cyc(1);
    check("idle 15 cycles after proc_start", to_busy, 0);
    check("timeout_err set", to_timeout_err, 1);
    check("dac_data kept on abort", to_dac_data, 'h123);
    check("sample_cnt kept on abort", to_sample_cnt, 1);
    cyc(1);
    check("no dac_load on abort", n_to_dac_load, t0);
    clr_err = 1'b1;
    cyc(1);
    clr_err = 1'b0;
    check("clr_err clears timeout_err", to_timeout_err, 0);

    // Stale adc_valid, then reset in PROC_WAIT
    do_reset();
    p0 = n_proc_start;
    adc_valid = 1'b1;
    cyc(2);
    pulse_tick();
    cyc(5);
    check("stale valid no capture", n_proc_start, p0);
    check("stale valid still busy", busy, 1);
    adc_valid = 1'b0;
    cyc(1);
    adc_data = 10'h055; adc_valid = 1'b1; exp_proc.push_back('h055);
    cyc(1);
    adc_valid = 1'b0;
    check("fresh edge proc_start", proc_start, 1);
    check("fresh edge proc_din", proc_din, 'h055);
    cyc(2);
    d0 = n_dac_load;
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    proc_dout = 10'h3AA; proc_done = 1'b1;
    cyc(3);
    proc_done = 1'b0;
    cyc(1);
    check("no dac_load after reset", n_dac_load, d0);
    check("busy after mid reset", busy, 0);
    check("dac_data after mid reset", dac_data, 0);
    check("proc_din after mid reset", proc_din, 0);
    check("sample_cnt after mid reset", sample_cnt, 0);

    cyc(2);
    check("proc scoreboard drained", exp_proc.size(), 0);
    check("dac scoreboard drained", exp_dac_data.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/sample_sequencer.md
# sample_sequencer

Per-sample scheduler for the 10 kHz audio path. On each sampling tick it starts one ADC conversion, waits for the sample, hands it to the processor with a start/done handshake, then loads the result into the DAC/PWM output register. It sits between the tick generator and the `spi2adc` / `processor` / `spi2dac` blocks, replacing free-running wiring with a checked, one-sample-in-flight sequence. It also reports overruns (a tick arrives while busy) and timeouts (a stalled stage).

## Interface
Parameters:
- `DW`, 10: sample width.
- `TIMEOUT`, 1023: maximum number of cycles spent in any wait state before abort.

Ports:
- `sysclk` in 1: system clock (50 MHz).
- `reset` in 1: synchronous, active-high reset.
- `tick` in 1: sampling strobe, one cycle wide.
- `bypass` in 1: 1 = route the ADC sample straight to the DAC and skip the processor.
- `clr_err` in 1: clears `timeout_err` and `overrun_cnt`.
- `adc_start` out 1: one-cycle conversion request to `spi2adc`.
- `adc_valid` in 1: data-valid from `spi2adc`; only its rising edge is used.
- `adc_data` in DW: converted sample.
- `proc_start` out 1: one-cycle start to the processor.
- `proc_din` out DW: sample presented to the processor, held stable until the next capture.
- `proc_done` in 1: processor result-valid, sampled as a level.
- `proc_dout` in DW: processor result.
- `dac_load` out 1: one-cycle strobe to `spi2dac` / `pwm`.
- `dac_data` out DW: output sample, held until the next load.
- `busy` out 1: high when the state is not IDLE.
- `overrun` out 1: one-cycle pulse for each dropped tick.
- `overrun_cnt` out 8: number of dropped ticks; saturates at 255.
- `timeout_err` out 1: sticky abort flag.
- `sample_cnt` out 16: number of completed samples; wraps.

## Operation
- States: IDLE, ADC_WAIT, PROC_WAIT.
- IDLE:
  - `tick`=1 → go to ADC_WAIT; `adc_start`=1 for one cycle; wait counter cleared.
  - `tick`=0 → stay in IDLE.
- ADC_WAIT, on the first cycle where `adc_valid`=1 and its previous registered value was 0:
  - Always: latch `proc_din`←`adc_data`.
  - `bypass`=0 → go to PROC_WAIT and pulse `proc_start`.
  - `bypass`=1 → latch `dac_data`←`adc_data`, pulse `dac_load`, increment `sample_cnt`, return to IDLE.
- PROC_WAIT, on `proc_done`=1 → latch `dac_data`←`proc_dout`, pulse `dac_load`, increment `sample_cnt`, go to IDLE.
- Timeout:
  - The wait counter increments every cycle in ADC_WAIT and PROC_WAIT and is cleared on every state change.
  - When the counter reaches `TIMEOUT` with no completing event, go to IDLE and set `timeout_err`.
  - On abort, `dac_load` is not pulsed, `dac_data` keeps its previous value, and `sample_cnt` is unchanged.
- Overrun:
  - A `tick` in any state other than IDLE is dropped. `overrun` pulses the next cycle and `overrun_cnt` increments, saturating at 255.
  - This includes a tick in the same cycle as a completion or abort, i.e. while the state is still ADC_WAIT or PROC_WAIT.
- `bypass` is sampled only at the ADC capture.
- `clr_err` is lower priority than a same-cycle overrun: the counter becomes 1 and the flag is cleared.
- Widths: all data paths are DW bits with no arithmetic. `sample_cnt` wraps modulo 2^16.

## Timing
- All outputs are registered.
- Reset values: state IDLE; `adc_start`, `proc_start`, `dac_load`, `overrun`, `busy`, `timeout_err` = 0; `proc_din`, `dac_data` = 0; `overrun_cnt`, `sample_cnt` = 0. The edge-detect register also resets to 0.
- `tick` high in cycle n (state IDLE) → `adc_start` and `busy` high in cycle n+1.
- `adc_valid` rising edge sampled in cycle m → `proc_start` high in m+1 (or `dac_load` in m+1 when bypassing).
- `proc_done` sampled in cycle k → `dac_load` high, new `dac_data`, and `busy`=0 in k+1.
- Earliest next accepted tick is the cycle in which `busy` reads 0.
- `adc_valid` already high on entry to ADC_WAIT does not capture; a fresh 0→1 edge is required.
- `reset` mid-sequence: all state returns to reset values on the next edge. Any in-flight handshake input arriving afterwards is ignored until a new tick.

## Structure
- Shared package `audio_pkg`:
  - `DW`;
  - the state enum `seq_state_t`;
  - `SEQ_TIMEOUT_DEFAULT`.
- Sub-module `wait_timer`: a loadable up-counter with clear and terminal-count flag, instanced once.
- The FSM, the edge detect, and the overrun/sample counters live in `sample_sequencer`.

## Test plan
- Normal run: tick; `adc_valid` edge with 0x2A5 after 40 cycles; `proc_done` with 0x15A after 3 cycles. Expect `proc_din`=0x2A5, one `dac_load` with `dac_data`=0x15A, `sample_cnt`=1, `busy` low 1 cycle after done.
- Bypass: `bypass`=1, ADC returns 0x3FF → `dac_data`=0x3FF, no `proc_start`, `dac_load` 1 cycle after the edge.
- Overrun: second tick 10 cycles after the first while in ADC_WAIT → one `overrun` pulse, `overrun_cnt`=1, only one `adc_start`. After 300 dropped ticks, `overrun_cnt`=255.
- Timeout: `TIMEOUT`=15, processor never completes → return to IDLE exactly 15 cycles after `proc_start`, `timeout_err`=1, `dac_data` unchanged, no `dac_load`. `clr_err` clears the flag.
- Stale valid: `adc_valid` held high from the previous sample, then a new tick → no capture until `adc_valid` drops and rises again.
- Reset mid-PROC_WAIT: assert `reset` for 1 cycle, then `proc_done`=1 → no `dac_load`, all outputs at reset values.
